// File: rtl/serdes_rx_sync_ctrl_pkg.sv
// Shared constants and state encoding for the SERDES receive sync controller.
package serdes_pkg;

  localparam int unsigned DEFAULT_BITS = 8;
  localparam logic [7:0]  COMMA_K28_5  = 8'hBC;

  typedef logic [2:0] state_t;

  localparam state_t ST_HUNT  = 3'd0;
  localparam state_t ST_SLIP  = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_CHECK = 3'd3;
  localparam state_t ST_SYNC  = 3'd4;

endpackage

// File: rtl/serdes_rx_sync_ctrl_if.sv
// Deserializer word stream in, aligned word stream and link status out.
interface serdes_rx_sync_ctrl_if #(
  parameter int unsigned BITS   = 8,
  parameter int unsigned SLIP_W = $clog2(BITS)
);
  logic              word_valid;
  logic [BITS-1:0]   word;
  logic              word_dk;
  logic              word_err;
  logic              bitslip;
  logic              sync_ok;
  logic              rx_valid;
  logic [BITS-1:0]   rx_data;
  logic              rx_dk;
  logic [SLIP_W-1:0] slip_cnt;
  logic              align_fail;
  logic [2:0]        err_cnt;

  modport master (
    output word_valid, word, word_dk, word_err,
    input  bitslip, sync_ok, rx_valid, rx_data, rx_dk, slip_cnt, align_fail, err_cnt
  );

  modport slave (
    input  word_valid, word, word_dk, word_err,
    output bitslip, sync_ok, rx_valid, rx_data, rx_dk, slip_cnt, align_fail, err_cnt
  );
endinterface

// File: rtl/serdes_rx_sync_ctrl_err_monitor.sv
// Leaky error counter: errors count up, each run of clean words forgives one.
module serdes_err_monitor #(
  parameter int unsigned LOSS_ERRORS = 4,
  parameter int unsigned GOOD_RUN    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       word_valid,
  input  logic       word_err,
  output logic [2:0] err_cnt,
  output logic       loss_of_sync
);
  localparam int unsigned GR_W = $clog2(GOOD_RUN + 1);

  logic [2:0]      err_cnt_q;
  logic [GR_W-1:0] good_q;

  assign loss_of_sync = enable & word_valid & word_err & (err_cnt_q == 3'(LOSS_ERRORS - 1));
  assign err_cnt      = err_cnt_q;

  // Update error and clean-run counts per valid word; the losing error zeroes the count.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      err_cnt_q <= '0;
      good_q    <= '0;
    end else if (enable && word_valid) begin
      if (word_err) begin
        good_q    <= '0;
        err_cnt_q <= loss_of_sync ? 3'd0 : err_cnt_q + 3'd1;
      end else if (good_q == GR_W'(GOOD_RUN - 1)) begin
        good_q <= '0;
        if (err_cnt_q != 3'd0) err_cnt_q <= err_cnt_q - 3'd1;
      end else begin
        good_q <= good_q + GR_W'(1);
      end
    end
  end
endmodule

// File: rtl/serdes_rx_sync_ctrl.sv
// Comma hunt, bitslip alignment, sync acquisition and in-sync word forwarding.
module serdes_rx_sync_ctrl
  import serdes_pkg::*;
#(
  parameter int unsigned     BITS         = DEFAULT_BITS,
  parameter logic [BITS-1:0] COMMA        = BITS'(COMMA_K28_5),
  parameter int unsigned     SEARCH_WORDS = 16,
  parameter int unsigned     SLIP_WAIT    = 2,
  parameter int unsigned     ACQ_COUNT    = 3,
  parameter int unsigned     LOSS_ERRORS  = 4,
  parameter int unsigned     GOOD_RUN     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  serdes_rx_sync_ctrl_if.slave bus
);
  localparam int unsigned SLIP_W = $clog2(BITS);
  localparam int unsigned HUNT_W = $clog2(SEARCH_WORDS + 1);
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int unsigned ACQ_W  = $clog2(ACQ_COUNT + 1);

  state_t            state_q, state_d;
  logic [HUNT_W-1:0] hunt_cnt_q, hunt_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [ACQ_W-1:0]  comma_cnt_q, comma_cnt_d;
  logic [SLIP_W-1:0] slip_cnt_q;
  logic              align_fail_q;
  logic              rx_valid_q, rx_dk_q;
  logic [BITS-1:0]   rx_data_q;
  logic              comma, forward, slip_enter, sync_enter, slip_wrap, loss_of_sync;
  logic [2:0]        err_cnt;

  assign comma      = bus.word_valid & bus.word_dk & (bus.word == COMMA) & ~bus.word_err;
  assign forward    = bus.word_valid & (state_q == ST_SYNC) & ~bus.word_err;
  assign slip_enter = (state_q == ST_HUNT) && (state_d == ST_SLIP);
  assign sync_enter = (state_q == ST_CHECK) && (state_d == ST_SYNC);
  assign slip_wrap  = (slip_cnt_q == SLIP_W'(BITS - 1));

  // Next state and hunt/settle/acquire counters.
  always_comb begin
    state_d     = state_q;
    hunt_cnt_d  = hunt_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    comma_cnt_d = comma_cnt_q;
    case (state_q)
      ST_HUNT: begin
        if (comma) begin
          state_d     = ST_CHECK;
          comma_cnt_d = ACQ_W'(1);
          hunt_cnt_d  = '0;
        end else if (bus.word_valid) begin
          if (hunt_cnt_q == HUNT_W'(SEARCH_WORDS - 1)) begin
            state_d    = ST_SLIP;
            hunt_cnt_d = '0;
          end else begin
            hunt_cnt_d = hunt_cnt_q + HUNT_W'(1);
          end
        end
      end
      // Incoming word is dropped while the deserializer shifts.
      ST_SLIP: begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        if (bus.word_valid) begin
          if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
            state_d    = ST_HUNT;
            hunt_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      // An error outranks a simultaneous comma.
      ST_CHECK: begin
        if (bus.word_valid && bus.word_err) begin
          state_d    = ST_HUNT;
          hunt_cnt_d = '0;
        end else if (comma) begin
          if (comma_cnt_q == ACQ_W'(ACQ_COUNT - 1)) state_d = ST_SYNC;
          else comma_cnt_d = comma_cnt_q + ACQ_W'(1);
        end
      end
      ST_SYNC: begin
        if (loss_of_sync) begin
          state_d    = ST_HUNT;
          hunt_cnt_d = '0;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // State, slip bookkeeping and the one-cycle forwarding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HUNT;
      hunt_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      comma_cnt_q  <= '0;
      slip_cnt_q   <= '0;
      align_fail_q <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_dk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hunt_cnt_q  <= hunt_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      if (slip_enter) begin
        slip_cnt_q <= slip_wrap ? '0 : slip_cnt_q + SLIP_W'(1);
        if (slip_wrap) align_fail_q <= 1'b1;
      end else if (sync_enter) begin
        slip_cnt_q   <= '0;
        align_fail_q <= 1'b0;
      end
      rx_valid_q <= forward;
      if (forward) begin
        rx_data_q <= bus.word;
        rx_dk_q   <= bus.word_dk;
      end
    end
  end

  serdes_err_monitor #(
    .LOSS_ERRORS(LOSS_ERRORS),
    .GOOD_RUN   (GOOD_RUN)
  ) u_err_monitor (
    .clk         (clk),
    .reset       (reset),
    .clear       (sync_enter),
    .enable      (state_q == ST_SYNC),
    .word_valid  (bus.word_valid),
    .word_err    (bus.word_err),
    .err_cnt     (err_cnt),
    .loss_of_sync(loss_of_sync)
  );

  assign bus.bitslip    = (state_q == ST_SLIP);
  assign bus.sync_ok    = (state_q == ST_SYNC);
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_dk      = rx_dk_q;
  assign bus.slip_cnt   = slip_cnt_q;
  assign bus.align_fail = align_fail_q;
  assign bus.err_cnt    = err_cnt;
endmodule

// File: tb/tb_serdes_rx_sync_ctrl.sv
// Directed bench for serdes_rx_sync_ctrl with a per-cycle reference model.
module tb_serdes_rx_sync_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;
  int   pulses = 0;
  logic prev_slip = 1'b0;

  always #5 clk = ~clk;

  serdes_rx_sync_ctrl_if #(.BITS(8)) bus ();

  serdes_rx_sync_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model: link phase plus plain integer counters.
  typedef enum {PhHunt, PhSlip, PhSettle, PhCheck, PhLocked} phase_t;
  phase_t   ph = PhHunt;
  int       run_words = 0, settle_left = 0, commas = 0, errs = 0, clean = 0, slips = 0;
  bit       m_bitslip = 0, m_sync = 0, m_rx_valid = 0, m_rx_dk = 0, m_align_fail = 0;
  bit [7:0] m_rx_data = 0;
  int       m_slip_cnt = 0;

  task automatic model_step(input bit rst, input bit v, input bit [7:0] w, input bit dk,
                            input bit err);
    bit is_comma;
    if (rst) begin
      ph = PhHunt; run_words = 0; settle_left = 0; commas = 0; errs = 0; clean = 0; slips = 0;
      m_bitslip = 0; m_sync = 0; m_rx_valid = 0; m_rx_dk = 0; m_align_fail = 0;
      m_rx_data = 0; m_slip_cnt = 0;
      return;
    end
    is_comma = v && dk && (w == 8'hBC) && !err;
    m_rx_valid = v && (ph == PhLocked) && !err;
    if (m_rx_valid) begin
      m_rx_data = w;
      m_rx_dk   = dk;
    end
    case (ph)
      PhHunt:
        if (is_comma) begin
          ph = PhCheck; commas = 1; run_words = 0;
        end else if (v) begin
          run_words++;
          if (run_words == 16) begin
            run_words = 0; ph = PhSlip; slips++;
            m_slip_cnt = slips % 8;
            if (m_slip_cnt == 0) m_align_fail = 1;
          end
        end
      PhSlip: begin
        ph = PhSettle; settle_left = 2;
      end
      PhSettle:
        if (v) begin
          settle_left--;
          if (settle_left == 0) begin
            ph = PhHunt; run_words = 0;
          end
        end
      PhCheck:
        if (v && err) begin
          ph = PhHunt; run_words = 0;
        end else if (is_comma) begin
          commas++;
          if (commas == 3) begin
            ph = PhLocked; slips = 0; m_slip_cnt = 0; m_align_fail = 0; errs = 0; clean = 0;
          end
        end
      PhLocked:
        if (v && err) begin
          errs++; clean = 0;
          if (errs == 4) begin
            errs = 0; ph = PhHunt; run_words = 0;
          end
        end else if (v) begin
          clean++;
          if (clean == 4) begin
            clean = 0;
            if (errs > 0) errs--;
          end
        end
      default: ph = PhHunt;
    endcase
    m_bitslip = (ph == PhSlip);
    m_sync    = (ph == PhLocked);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model half a cycle after each edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("bitslip", 32'(bus.bitslip), 32'(m_bitslip));
      chk("sync_ok", 32'(bus.sync_ok), 32'(m_sync));
      chk("rx_valid", 32'(bus.rx_valid), 32'(m_rx_valid));
      chk("rx_data", 32'(bus.rx_data), 32'(m_rx_data));
      chk("rx_dk", 32'(bus.rx_dk), 32'(m_rx_dk));
      chk("slip_cnt", 32'(bus.slip_cnt), 32'(m_slip_cnt));
      chk("align_fail", 32'(bus.align_fail), 32'(m_align_fail));
      chk("err_cnt", 32'(bus.err_cnt), 32'(errs));
      chk("bitslip_back_to_back", 32'(bus.bitslip & prev_slip), 32'd0);
      if (bus.bitslip === 1'b1 && prev_slip == 1'b0) pulses <= pulses + 1;
      prev_slip <= bus.bitslip;
    end
  end

  task automatic drive(input bit rst, input bit v, input bit [7:0] w, input bit dk,
                       input bit err);
    reset          = rst;
    bus.word_valid = v;
    bus.word       = w;
    bus.word_dk    = dk;
    bus.word_err   = err;
    @(posedge clk);
    model_step(rst, v, w, dk, err);
    #1;
  endtask

  task automatic comma_w();
    drive(0, 1, 8'hBC, 1, 0);
  endtask
  task automatic data_w();
    drive(0, 1, 8'h88, 0, 0);
  endtask
  task automatic err_w();
    drive(0, 1, 8'h55, 0, 1);
  endtask
  task automatic idle_w();
    drive(0, 0, 8'h00, 0, 0);
  endtask
  task automatic lose_sync();
    for (int i = 0; i < 4; i++) err_w();
  endtask

  int base;

  initial begin
    reset = 1'b1;
    bus.word_valid = 1'b0; bus.word = '0; bus.word_dk = 1'b0; bus.word_err = 1'b0;
    drive(1, 0, 8'h00, 0, 0);
    chk_en = 1'b1;
    drive(1, 0, 8'h00, 0, 0);
    chk("reset_sync_ok", 32'(bus.sync_ok), 32'd0);
    chk("reset_slip_cnt", 32'(bus.slip_cnt), 32'd0);

    // Acquisition with data between commas, then forwarding.
    comma_w(); data_w(); comma_w(); data_w();
    chk("acq_not_yet", 32'(bus.sync_ok), 32'd0);
    comma_w();
    chk("acq_sync_ok", 32'(bus.sync_ok), 32'd1);
    chk("acq_comma_not_fwd", 32'(bus.rx_valid), 32'd0);
    data_w();
    chk("fwd_valid", 32'(bus.rx_valid), 32'd1);
    chk("fwd_data", 32'(bus.rx_data), 32'h88);
    chk("fwd_dk", 32'(bus.rx_dk), 32'd0);

    // Errors too dense to be forgiven drop sync.
    err_w();
    chk("err_no_fwd", 32'(bus.rx_valid), 32'd0);
    chk("err_cnt_1", 32'(bus.err_cnt), 32'd1);
    data_w(); err_w(); data_w(); err_w(); err_w();
    chk("loss_sync_ok", 32'(bus.sync_ok), 32'd0);
    chk("loss_err_cnt", 32'(bus.err_cnt), 32'd0);

    // Sixteen data words force one slip; settle words are discarded even if commas.
    for (int i = 0; i < 15; i++) data_w();
    chk("slip_not_yet", 32'(bus.bitslip), 32'd0);
    data_w();
    chk("slip_pulse", 32'(bus.bitslip), 32'd1);
    chk("slip_cnt_1", 32'(bus.slip_cnt), 32'd1);
    comma_w(); comma_w(); comma_w();
    chk("settle_ignored", 32'(bus.sync_ok), 32'd0);
    comma_w(); comma_w(); comma_w();
    chk("slip_then_sync", 32'(bus.sync_ok), 32'd1);
    chk("sync_clears_slip_cnt", 32'(bus.slip_cnt), 32'd0);

    // Sparse errors are forgiven; sync holds.
    for (int k = 0; k < 10; k++) begin
      err_w();
      chk("leaky_up", 32'(bus.err_cnt), 32'd1);
      for (int j = 0; j < 4; j++) data_w();
      chk("leaky_down", 32'(bus.err_cnt), 32'd0);
      chk("leaky_sync_ok", 32'(bus.sync_ok), 32'd1);
    end

    // Error coinciding with a comma in CHECK returns to hunting.
    lose_sync();
    comma_w();
    drive(0, 1, 8'hBC, 1, 1);
    comma_w(); comma_w();
    chk("err_comma_restart", 32'(bus.sync_ok), 32'd0);
    comma_w();
    chk("err_comma_resync", 32'(bus.sync_ok), 32'd1);

    // Eight slips with no sync wrap the slip count and flag alignment failure.
    lose_sync();
    base = pulses;
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 16; i++) data_w();
      idle_w();
      data_w(); data_w();
    end
    chk("eight_pulses", 32'(pulses - base), 32'd8);
    chk("wrap_slip_cnt", 32'(bus.slip_cnt), 32'd0);
    chk("align_fail_set", 32'(bus.align_fail), 32'd1);
    comma_w(); comma_w(); comma_w();
    chk("align_fail_cleared", 32'(bus.align_fail), 32'd0);

    // Reset while in sync with forwarding active.
    err_w(); data_w();
    chk("pre_reset_rx_valid", 32'(bus.rx_valid), 32'd1);
    chk("pre_reset_err_cnt", 32'(bus.err_cnt), 32'd1);
    drive(1, 1, 8'h88, 0, 0);
    chk("rst_sync_ok", 32'(bus.sync_ok), 32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("rst_bitslip", 32'(bus.bitslip), 32'd0);
    chk("rst_slip_cnt", 32'(bus.slip_cnt), 32'd0);

    // Reset during the slip cycle cancels the pulse.
    for (int i = 0; i < 16; i++) data_w();
    chk("pre_reset_slip", 32'(bus.bitslip), 32'd1);
    drive(1, 1, 8'h88, 0, 0);
    chk("rst_mid_slip_bitslip", 32'(bus.bitslip), 32'd0);
    chk("rst_mid_slip_cnt", 32'(bus.slip_cnt), 32'd0);
    idle_w(); idle_w();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
